// File: rtl/mem_arb_pkg.sv
// Shared definitions for the MCB write/command port arbiter:
// FSM state encoding, MCB command opcodes and write FIFO depth.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

    localparam logic [2:0] MCB_INSTR_WRITE    = 3'b000;
    localparam logic [2:0] MCB_INSTR_READ     = 3'b001;
    localparam logic [2:0] MCB_INSTR_WRITE_AP = 3'b010;
    localparam logic [2:0] MCB_INSTR_READ_AP  = 3'b011;

    localparam int MCB_WR_DEPTH = 64;
    localparam int PEND_W       = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the MCB user port. The arbiter uses the
// slave view; the environment (requesters plus memory controller) uses master.
interface mem_port_arbiter_if;

    logic        r0_req,       r1_req;
    logic        r0_grant,     r1_grant;
    logic        r0_cmd_en,    r1_cmd_en;
    logic [2:0]  r0_cmd_instr, r1_cmd_instr;
    logic [5:0]  r0_cmd_bl,    r1_cmd_bl;
    logic [29:0] r0_cmd_byte_addr, r1_cmd_byte_addr;
    logic        r0_wr_en,     r1_wr_en;
    logic [3:0]  r0_wr_mask,   r1_wr_mask;
    logic [31:0] r0_wr_data,   r1_wr_data;
    logic        r0_cmd_full,  r1_cmd_full;
    logic        r0_wr_full,   r1_wr_full;
    logic        r0_cmd_empty, r1_cmd_empty;
    logic        r0_wr_empty,  r1_wr_empty;
    logic [6:0]  r0_wr_count,  r1_wr_count;
    logic        r0_wr_underrun, r1_wr_underrun;
    logic        r0_wr_error,  r1_wr_error;

    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_cmd_full, mem_cmd_empty;
    logic        mem_wr_full,  mem_wr_empty;
    logic [6:0]  mem_wr_count;
    logic        mem_wr_underrun, mem_wr_error;

    modport slave (
        input  r0_req, r0_cmd_en, r0_cmd_instr, r0_cmd_bl, r0_cmd_byte_addr,
               r0_wr_en, r0_wr_mask, r0_wr_data,
               r1_req, r1_cmd_en, r1_cmd_instr, r1_cmd_bl, r1_cmd_byte_addr,
               r1_wr_en, r1_wr_mask, r1_wr_data,
               mem_cmd_full, mem_cmd_empty, mem_wr_full, mem_wr_empty,
               mem_wr_count, mem_wr_underrun, mem_wr_error,
        output r0_grant, r0_cmd_full, r0_wr_full, r0_cmd_empty, r0_wr_empty,
               r0_wr_count, r0_wr_underrun, r0_wr_error,
               r1_grant, r1_cmd_full, r1_wr_full, r1_cmd_empty, r1_wr_empty,
               r1_wr_count, r1_wr_underrun, r1_wr_error,
               mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
               mem_wr_en, mem_wr_mask, mem_wr_data
    );

    modport master (
        output r0_req, r0_cmd_en, r0_cmd_instr, r0_cmd_bl, r0_cmd_byte_addr,
               r0_wr_en, r0_wr_mask, r0_wr_data,
               r1_req, r1_cmd_en, r1_cmd_instr, r1_cmd_bl, r1_cmd_byte_addr,
               r1_wr_en, r1_wr_mask, r1_wr_data,
               mem_cmd_full, mem_cmd_empty, mem_wr_full, mem_wr_empty,
               mem_wr_count, mem_wr_underrun, mem_wr_error,
        input  r0_grant, r0_cmd_full, r0_wr_full, r0_cmd_empty, r0_wr_empty,
               r0_wr_count, r0_wr_underrun, r0_wr_error,
               r1_grant, r1_cmd_full, r1_wr_full, r1_cmd_empty, r1_wr_empty,
               r1_wr_count, r1_wr_underrun, r1_wr_error,
               mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
               mem_wr_en, mem_wr_mask, mem_wr_data
    );

endinterface

// File: rtl/mem_arb_pending_tracker.sv
// Counts write words pushed but not yet consumed by a write command, with
// saturation at 0 and the FIFO depth; flags underflow, overflow, dirty release.
module mem_arb_pending_tracker
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr,
    input  logic              i_cmd_wr,
    input  logic [5:0]        i_cmd_bl,
    input  logic              i_release,
    output logic [PEND_W-1:0] o_count,
    output logic              o_err
);

    localparam logic signed [9:0] DEPTH_S = MCB_WR_DEPTH[9:0];

    logic [PEND_W-1:0] r_count;
    logic signed [9:0] w_inc, w_dec, w_sum;
    logic [PEND_W-1:0] w_sat;
    logic              w_under, w_over, w_rel_err;

    always_comb begin
        w_inc     = i_wr ? 10'sd1 : 10'sd0;
        w_dec     = i_cmd_wr ? ($signed({4'b0000, i_cmd_bl}) + 10'sd1) : 10'sd0;
        w_sum     = $signed({2'b00, r_count}) + w_inc - w_dec;
        w_under   = (w_sum < 10'sd0);
        w_over    = (w_sum > DEPTH_S);
        w_sat     = w_under ? '0 : (w_over ? DEPTH_S[PEND_W-1:0] : w_sum[PEND_W-1:0]);
        // Release is judged on the count after this cycle's beat is applied.
        w_rel_err = i_release && (w_sat != '0);
        o_err     = w_under || w_over || w_rel_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_release) begin
            r_count <= '0;
        end else begin
            r_count <= w_sat;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, whole-transaction owner of the MCB write/command port shared by
// the SD loader (r0) and the CPU/video path (r1), with a dead cycle between owners.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              protocol_error
);

    arb_state_t        r_state, w_state_nxt;
    logic              r_last_grant, w_last_nxt;
    logic              r_perr;
    logic              w_release;
    logic              w_gnt0, w_gnt1;
    logic              w_ungranted;
    logic              w_trk_err;
    logic [PEND_W-1:0] w_pending;

    logic              w_cmd_en, w_wr_en;
    logic [2:0]        w_cmd_instr;
    logic [5:0]        w_cmd_bl;
    logic [29:0]       w_cmd_addr;
    logic [3:0]        w_wr_mask;
    logic [31:0]       w_wr_data;

    assign w_gnt0 = (r_state == ST_GRANT0);
    assign w_gnt1 = (r_state == ST_GRANT1);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the requester not served last wins.
                if (bus.r0_req && bus.r1_req)
                    w_state_nxt = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                else if (bus.r0_req)
                    w_state_nxt = ST_GRANT0;
                else if (bus.r1_req)
                    w_state_nxt = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (!bus.r0_req) begin
                    w_state_nxt = ST_GAP;
                    w_last_nxt  = 1'b0;
                    w_release   = 1'b1;
                end
            end
            ST_GRANT1: begin
                if (!bus.r1_req) begin
                    w_state_nxt = ST_GAP;
                    w_last_nxt  = 1'b1;
                    w_release   = 1'b1;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    always_comb begin
        w_cmd_en    = 1'b0;
        w_cmd_instr = '0;
        w_cmd_bl    = '0;
        w_cmd_addr  = '0;
        w_wr_en     = 1'b0;
        w_wr_mask   = '0;
        w_wr_data   = '0;
        if (w_gnt0) begin
            w_cmd_en    = bus.r0_cmd_en;
            w_cmd_instr = bus.r0_cmd_instr;
            w_cmd_bl    = bus.r0_cmd_bl;
            w_cmd_addr  = bus.r0_cmd_byte_addr;
            w_wr_en     = bus.r0_wr_en;
            w_wr_mask   = bus.r0_wr_mask;
            w_wr_data   = bus.r0_wr_data;
        end else if (w_gnt1) begin
            w_cmd_en    = bus.r1_cmd_en;
            w_cmd_instr = bus.r1_cmd_instr;
            w_cmd_bl    = bus.r1_cmd_bl;
            w_cmd_addr  = bus.r1_cmd_byte_addr;
            w_wr_en     = bus.r1_wr_en;
            w_wr_mask   = bus.r1_wr_mask;
            w_wr_data   = bus.r1_wr_data;
        end
    end

    assign bus.mem_cmd_en        = w_cmd_en;
    assign bus.mem_cmd_instr     = w_cmd_instr;
    assign bus.mem_cmd_bl        = w_cmd_bl;
    assign bus.mem_cmd_byte_addr = w_cmd_addr;
    assign bus.mem_wr_en         = w_wr_en;
    assign bus.mem_wr_mask       = w_wr_mask;
    assign bus.mem_wr_data       = w_wr_data;

    assign bus.r0_grant       = w_gnt0;
    assign bus.r1_grant       = w_gnt1;
    assign bus.r0_cmd_full    = w_gnt0 ? bus.mem_cmd_full : 1'b1;
    assign bus.r0_wr_full     = w_gnt0 ? bus.mem_wr_full  : 1'b1;
    assign bus.r1_cmd_full    = w_gnt1 ? bus.mem_cmd_full : 1'b1;
    assign bus.r1_wr_full     = w_gnt1 ? bus.mem_wr_full  : 1'b1;
    assign bus.r0_cmd_empty   = bus.mem_cmd_empty;
    assign bus.r1_cmd_empty   = bus.mem_cmd_empty;
    assign bus.r0_wr_empty    = bus.mem_wr_empty;
    assign bus.r1_wr_empty    = bus.mem_wr_empty;
    assign bus.r0_wr_count    = bus.mem_wr_count;
    assign bus.r1_wr_count    = bus.mem_wr_count;
    assign bus.r0_wr_underrun = bus.mem_wr_underrun;
    assign bus.r1_wr_underrun = bus.mem_wr_underrun;
    assign bus.r0_wr_error    = bus.mem_wr_error;
    assign bus.r1_wr_error    = bus.mem_wr_error;

    // Activity from a requester that does not own the port is dropped and flagged.
    assign w_ungranted = ((bus.r0_cmd_en || bus.r0_wr_en) && !w_gnt0) ||
                         ((bus.r1_cmd_en || bus.r1_wr_en) && !w_gnt1);

    mem_arb_pending_tracker u_trk (
        .clk       (clk),
        .reset     (reset),
        .i_wr      (w_wr_en),
        .i_cmd_wr  (w_cmd_en && !w_cmd_instr[0]),
        .i_cmd_bl  (w_cmd_bl),
        .i_release (w_release),
        .o_count   (w_pending),
        .o_err     (w_trk_err)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_perr <= 1'b0;
        else if (w_trk_err || w_ungranted)
            r_perr <= 1'b1;
    end

    assign protocol_error = r_perr;

endmodule
